// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for common-anode BCD displays: a shadow register of
// DIGITS BCD values, a one-cycle dead time between slots, leading-zero blanking and per-digit blink.
module display_scan_driver #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLINK_FRAMES    = 64
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [4*DIGITS-1:0]         Digits,
  input  logic                        Load,
  input  logic                        BlankLeadingZeros,
  input  logic [DIGITS-1:0]           BlinkMask,
  output logic [3:0]                  ActiveDigit,
  output logic [DIGITS-1:0]           DigitEnable,
  output logic [$clog2(DIGITS)-1:0]   ScanIndex,
  output logic                        FrameStart
);

  localparam int SW = $clog2(DIGITS);
  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic                   blink_q, blink_d;
  logic [3:0]             digit_q, digit_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic                   fs_q, fs_d;

  logic                   tick_end, wrap, blanked;
  logic [DIGITS-1:0]      lz;

  always_comb begin
    shadow_d = Load ? Digits : shadow_q;
    tick_end = (tick_q == TW'(TICKS_PER_DIGIT - 1));
    wrap     = tick_end && (scan_q == SW'(DIGITS - 1));
    tick_d   = tick_end ? '0 : tick_q + 1'b1;
    scan_d   = scan_q;
    if (tick_end) scan_d = wrap ? '0 : scan_q + 1'b1;

    frame_d = frame_q;
    blink_d = blink_q;
    if (wrap) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // lz[i]: digits i..DIGITS-1 are all zero. Uses the incoming shadow so a
    // load coinciding with the end of the dead cycle is already visible.
    lz = '0;
    lz[DIGITS-1] = (shadow_d[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (shadow_d[i] == 4'd0);

    blanked = (BlankLeadingZeros && (scan_q != '0) && lz[scan_q]) ||
              (BlinkMask[scan_q] && blink_q);

    digit_d = digit_q;
    en_d    = en_q;
    if (tick_end) begin
      en_d = '1;
    end else if (tick_q == '0) begin
      if (blanked) begin
        digit_d = 4'hF;
        en_d    = '1;
      end else begin
        digit_d = shadow_d[scan_q];
        en_d    = ~(DIGITS'(1) << scan_q);
      end
    end
    fs_d = wrap;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_q <= '0;
      tick_q   <= '0;
      scan_q   <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      digit_q  <= 4'hF;
      en_q     <= '1;
      fs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      scan_q   <= scan_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      digit_q  <= digit_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
    end
  end

  assign ActiveDigit = digit_q;
  assign DigitEnable = en_q;
  assign ScanIndex   = scan_q;
  assign FrameStart  = fs_q;

endmodule
